// File: rtl/popcount_arb_ctrl.sv
// Round-robin two-source arbiter feeding a serial bit-population counter.
// Optional POPCNT_EARLY_EXIT_EN: finish the scan once no 1 bits remain.
module popcount_arb_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic             out_id,
    output logic [CNT_W-1:0] out_ones,
    output logic [CNT_W-1:0] out_zeroes,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] WORD_LEN = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] ones;
    logic [CNT_W-1:0] zeroes;
    logic             id;
    logic             last_grant;
    logic             grant0;
    logic             grant1;
    logic             early_hit;

    // Ready is gated by rst so nothing looks accepted while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !rst) begin
            grant0 = req0_valid && (!req1_valid || last_grant);
            grant1 = req1_valid && (!req0_valid || !last_grant);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

`ifdef POPCNT_EARLY_EXIT_EN
    assign early_hit = (shreg == '0);
`else
    assign early_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            idx        <= '0;
            ones       <= '0;
            zeroes     <= '0;
            id         <= 1'b0;
            last_grant <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        shreg      <= grant1 ? req1_data : req0_data;
                        id         <= grant1;
                        last_grant <= grant1;
                        ones       <= '0;
                        zeroes     <= '0;
                        idx        <= '0;
                        busy       <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (early_hit) begin
                        // Remaining bits are all zero: credit them at once.
                        zeroes    <= zeroes + (WORD_LEN - idx);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        if (shreg[0]) begin
                            ones <= ones + ONE;
                        end else begin
                            zeroes <= zeroes + ONE;
                        end
                        shreg <= shreg >> 1;
                        idx   <= idx + ONE;
                        if (idx == LAST_IDX) begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign out_id     = id;
    assign out_ones   = ones;
    assign out_zeroes = zeroes;

endmodule
